// File: rtl/alu_pkg.sv
// Shared ALU control codes and execute-stage FSM encoding.
// The ALU control decoder drives alu_ctrl with these same constants.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  // True for the only multi-cycle operation; every other code retires in one cycle.
  function automatic logic is_mul(input logic [3:0] code);
    return (code == ALU_MUL);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between operand muxing and the execute stage.
// master issues requests; slave is the execute unit.
interface alu_exec_unit_if #(
  parameter int WIDTH = 64
) ();
  logic             start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output start, alu_ctrl, op_a, op_b,
    input  busy, done, result, zero, illegal
  );

  modport slave (
    input  start, alu_ctrl, op_a, op_b,
    output busy, done, result, zero, illegal
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier core: one multiplier bit per cycle, fixed WIDTH steps.
// done flags the cycle in which the last step happens; product is the
// accumulator value including that step, so the owner can register it directly.
module alu_mul_iter #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] addend;

  // Partial product for this step: multiplicand gated by the current multiplier LSB.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
    assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
  end

  assign product = acc_reg + addend;
  assign done    = (cnt_reg == CNT_W'(1));

  // Load operands on start, otherwise advance one step while steps remain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
    end else if (start) begin
      acc_reg    <= '0;
      mcand_reg  <= a;
      mplier_reg <= b;
      cnt_reg    <= CNT_W'(WIDTH);
    end else if (cnt_reg != '0) begin
      acc_reg    <= product;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle AND/OR/ADD/SUB, iterative MUL, start/busy/done handshake.
// Results are registered and held until the next done pulse.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_exec_unit_if.slave    bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state_reg, state_next;
  logic             busy;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] op_result;
  logic             op_illegal;
  logic [WIDTH-1:0] result_reg;
  logic             zero_reg;
  logic             illegal_reg;
  logic             done_reg;

  assign accept    = bus.start & ~busy;
  assign mul_start = accept & is_mul(bus.alu_ctrl);

  alu_mul_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (bus.op_a),
    .b       (bus.op_b),
    .done    (mul_done),
    .product (mul_product)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next state: enter MUL on a multiply accept, leave after the final step.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (mul_start) state_next = MUL;
      MUL:     if (mul_done)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: busy only while iterating, so the done cycle can accept a new request.
  always_comb begin
    busy = (state_reg == MUL);
  end

  // Single-cycle operations; unsupported codes yield zero and raise illegal.
  always_comb begin
    op_result  = '0;
    op_illegal = 1'b0;
    case (bus.alu_ctrl)
      ALU_AND: op_result = bus.op_a & bus.op_b;
      ALU_OR:  op_result = bus.op_a | bus.op_b;
      ALU_ADD: op_result = bus.op_a + bus.op_b;
      ALU_SUB: op_result = bus.op_a - bus.op_b;
      default: op_illegal = 1'b1;
    endcase
  end

  // Output registers: capture on single-cycle accept or on the last MUL step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg  <= '0;
      zero_reg    <= 1'b1;
      illegal_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == IDLE && accept && !is_mul(bus.alu_ctrl)) begin
        result_reg  <= op_result;
        zero_reg    <= (op_result == '0);
        illegal_reg <= op_illegal;
        done_reg    <= 1'b1;
      end else if (state_reg == MUL && mul_done) begin
        result_reg  <= mul_product;
        zero_reg    <= (mul_product == '0);
        illegal_reg <= 1'b0;
        done_reg    <= 1'b1;
      end
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done_reg;
  assign bus.result  = result_reg;
  assign bus.zero    = zero_reg;
  assign bus.illegal = illegal_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: scoreboard of expected results
// (value, flags, completion cycle) popped and compared on every done pulse.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int WIDTH = 64;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             ill;
    int               cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  exp_t sb_q[$];

  alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("txn %s: result=%h zero=%0b illegal=%0b cycle=%0d", e.tag, bus.result, bus.zero, bus.illegal, cyc);
        check({e.tag, "_result"}, bus.result, e.res);
        check({e.tag, "_zero"}, WIDTH'(bus.zero), WIDTH'(e.zero));
        check({e.tag, "_illegal"}, WIDTH'(bus.illegal), WIDTH'(e.ill));
        check({e.tag, "_cycle"}, WIDTH'(cyc), WIDTH'(e.cyc));
        check({e.tag, "_busy_at_done"}, WIDTH'(bus.busy), 0);
      end
    end
  end

  // Called at a negedge: drives one request for one cycle and records its expectation.
  task automatic issue(input string tag, input logic [3:0] code,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    e.tag = tag;
    e.ill = 1'b0;
    case (code)
      ALU_AND: e.res = a & b;
      ALU_OR:  e.res = a | b;
      ALU_ADD: e.res = a + b;
      ALU_SUB: e.res = a - b;
      ALU_MUL: e.res = a * b;
      default: begin e.res = '0; e.ill = 1'b1; end
    endcase
    e.zero = (e.res == '0);
    e.cyc  = cyc + 1 + ((code == ALU_MUL) ? WIDTH : 0);
    sb_q.push_back(e);
    bus.start    = 1'b1;
    bus.alu_ctrl = code;
    bus.op_a     = a;
    bus.op_b     = b;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.op_a     = {$urandom, $urandom};
    bus.op_b     = {$urandom, $urandom};
  endtask

  // Returns at the negedge where done is seen; counts busy cycles on the way.
  task automatic wait_done(input string tag, output int busy_cnt);
    busy_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.done === 1'b1) return;
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
    end
    check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int bc;
    logic [WIDTH-1:0] ra, rb;
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.alu_ctrl = 4'b0;
    bus.op_a = '0;
    bus.op_b = '0;

    // Reset values, release mid-clock.
    @(negedge clk);
    check("rst_busy", WIDTH'(bus.busy), 0);
    check("rst_done", WIDTH'(bus.done), 0);
    check("rst_result", bus.result, 0);
    check("rst_zero", WIDTH'(bus.zero), 1);
    check("rst_illegal", WIDTH'(bus.illegal), 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single-cycle ops.
    issue("add_5_7", ALU_ADD, 64'd5, 64'd7);          wait_done("add_5_7", bc);
    issue("sub_9_9", ALU_SUB, 64'd9, 64'd9);          wait_done("sub_9_9", bc);
    issue("sub_0_1", ALU_SUB, 64'd0, 64'd1);          wait_done("sub_0_1", bc);
    issue("and", ALU_AND, 64'hF0F0, 64'h0FF0);        wait_done("and", bc);
    issue("or", ALU_OR, 64'hF0F0, 64'h0FF0);          wait_done("or", bc);
    issue("illegal_f", 4'b1111, 64'h1234, 64'h5678); wait_done("illegal_f", bc);
    issue("illegal_3", 4'b0011, 64'hFF, 64'h1);      wait_done("illegal_3", bc);

    // Multiplies.
    issue("mul_6_7", ALU_MUL, 64'd6, 64'd7);
    wait_done("mul_6_7", bc);
    check("mul_6_7_busy_cycles", WIDTH'(bc), WIDTH'(WIDTH));
    issue("mul_2p63_2", ALU_MUL, 64'h8000_0000_0000_0000, 64'd2); wait_done("mul_2p63_2", bc);
    issue("mul_m1_m1", ALU_MUL, '1, '1);                         wait_done("mul_m1_m1", bc);

    // Start during busy is ignored; start in the done cycle is accepted.
    issue("mul_3_5", ALU_MUL, 64'd3, 64'd5);
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.alu_ctrl = ALU_ADD; bus.op_a = 64'd1; bus.op_b = 64'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("mul_3_5", bc);
    issue("b2b_add", ALU_ADD, 64'd2, 64'd3);          wait_done("b2b_add", bc);
    issue("b2b_mul", ALU_MUL, 64'd11, 64'd13);        wait_done("b2b_mul", bc);
    issue("b2b_sub", ALU_SUB, 64'd100, 64'd1);        wait_done("b2b_sub", bc);

    // A few random operations against the bench model.
    for (int i = 0; i < 4; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      issue($sformatf("rnd_add_%0d", i), ALU_ADD, ra, rb); wait_done("rnd_add", bc);
      issue($sformatf("rnd_mul_%0d", i), ALU_MUL, ra, rb); wait_done("rnd_mul", bc);
    end

    // Reset in the middle of a multiply.
    issue("pre_rst_add", ALU_ADD, 64'd1, 64'd2);      wait_done("pre_rst_add", bc);
    issue("mul_aborted", ALU_MUL, 64'h1234, 64'h5678);
    repeat (9) @(posedge clk);
    check("mid_mul_busy", WIDTH'(bus.busy), 1);
    #2 rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("abort_busy", WIDTH'(bus.busy), 0);
    check("abort_done", WIDTH'(bus.done), 0);
    check("abort_result", bus.result, 0);
    check("abort_zero", WIDTH'(bus.zero), 1);
    check("abort_illegal", WIDTH'(bus.illegal), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (WIDTH + 4) @(negedge clk);
    check("post_abort_busy", WIDTH'(bus.busy), 0);
    issue("post_rst_add", ALU_ADD, 64'd1, 64'd1);     wait_done("post_rst_add", bc);
    @(negedge clk);
    check("scoreboard_empty", WIDTH'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
